// File: rtl/mod_exp_engine.sv
// mod_exp_engine: iterative c = base^exponent mod modulo.
// Right-to-left binary exponentiation over the exponent bits (LSB first),
// built on interleaved shift-add modular multipliers.
// Optional build macro: MOD_EXP_EARLY_EXIT_EN. When it is defined, the engine
// finishes as soon as the remaining exponent bits are all zero.
// Ports:
//   clk_in    - system clock, rising edge
//   rst_in    - synchronous active-low reset
//   base      - operand (may be >= modulo)
//   exponent  - exponent
//   modulo    - modulus (zero flags an error)
//   valid_in  - request, accepted when busy_out is low
//   c_out     - result, held until the next result
//   valid_out - one-cycle result strobe
//   error_out - zero-modulus flag, only with valid_out
//   busy_out  - engine occupied, valid_in ignored
module mod_exp_engine #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned EXP_WIDTH = WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulo,
  input  logic                 valid_in,
  output logic [WIDTH-1:0]     c_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic                 busy_out
);

  localparam int unsigned ACC_W  = WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned STEP_W = $clog2(EXP_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [WIDTH-1:0]     m_q, r_q, res_q, mplier_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [ACC_W-1:0]     acc_a, acc_b;
  logic [CNT_W-1:0]     bit_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic                 err_q;

  logic [ACC_W-1:0]     acc_a_nxt_c, acc_b_nxt_c;
  logic [WIDTH-1:0]     b_mcand_c;
  logic                 last_bit_c, last_step_c, reduce_exit_c, step_exit_c;

  // One interleaved step: acc = (2*acc + bit*x) mod m, with acc < m and x <= m.
  function automatic logic [ACC_W-1:0] mm_step(input logic [ACC_W-1:0] acc,
                                               input logic [WIDTH-1:0] x,
                                               input logic             b,
                                               input logic [WIDTH-1:0] m);
    logic [ACC_W-1:0] t;
    t = acc << 1;
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (b) t = t + {1'b0, x};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t;
  endfunction

  // Multiplier datapaths; both products in STEP share the multiplier bits of r.
  always_comb begin
    b_mcand_c   = (state == S_REDUCE) ? WIDTH'(1) : r_q;
    acc_a_nxt_c = mm_step(acc_a, res_q, mplier_q[WIDTH-1], m_q);
    acc_b_nxt_c = mm_step(acc_b, b_mcand_c, mplier_q[WIDTH-1], m_q);
    last_bit_c  = (bit_cnt == CNT_W'(WIDTH - 1));
    last_step_c = (step_cnt == STEP_W'(EXP_WIDTH - 1));
`ifdef MOD_EXP_EARLY_EXIT_EN
    reduce_exit_c = (exp_q == '0);
    step_exit_c   = last_step_c || ((exp_q >> 1) == '0);
`else
    reduce_exit_c = 1'b0;
    step_exit_c   = last_step_c;
`endif
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (valid_in) state_nxt = (modulo == '0) ? S_DONE : S_REDUCE;
      S_REDUCE: if (last_bit_c) state_nxt = reduce_exit_c ? S_DONE : S_STEP;
      S_STEP:   if (last_bit_c && step_exit_c) state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      m_q       <= '0;
      r_q       <= '0;
      res_q     <= '0;
      mplier_q  <= '0;
      exp_q     <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      bit_cnt   <= '0;
      step_cnt  <= '0;
      err_q     <= 1'b0;
      c_out     <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            m_q      <= modulo;
            exp_q    <= exponent;
            mplier_q <= base;
            r_q      <= '0;
            res_q    <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            bit_cnt  <= '0;
            step_cnt <= '0;
            err_q    <= (modulo == '0);
            busy_out <= 1'b1;
          end
        end
        // r = base*1 mod m, scanning base as the multiplier so base >= m is safe.
        S_REDUCE: begin
          acc_b    <= acc_b_nxt_c;
          mplier_q <= mplier_q << 1;
          bit_cnt  <= bit_cnt + CNT_W'(1);
          if (last_bit_c) begin
            r_q      <= acc_b_nxt_c[WIDTH-1:0];
            mplier_q <= acc_b_nxt_c[WIDTH-1:0];
            res_q    <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            acc_b    <= '0;
            bit_cnt  <= '0;
          end
        end
        S_STEP: begin
          acc_a    <= acc_a_nxt_c;
          acc_b    <= acc_b_nxt_c;
          mplier_q <= mplier_q << 1;
          bit_cnt  <= bit_cnt + CNT_W'(1);
          if (last_bit_c) begin
            if (exp_q[0]) res_q <= acc_a_nxt_c[WIDTH-1:0];
            r_q      <= acc_b_nxt_c[WIDTH-1:0];
            mplier_q <= acc_b_nxt_c[WIDTH-1:0];
            exp_q    <= exp_q >> 1;
            step_cnt <= step_cnt + STEP_W'(1);
            acc_a    <= '0;
            acc_b    <= '0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          valid_out <= 1'b1;
          error_out <= err_q;
          c_out     <= err_q ? '0 : res_q;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine (WIDTH = EXP_WIDTH = 10).
module tb_mod_exp_engine;

  localparam int unsigned W  = 10;
  localparam int unsigned EW = 10;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exponent = '0;
  logic [W-1:0]  modulo = '0;
  logic          valid_in = 1'b0;
  logic [W-1:0]  c_out;
  logic          valid_out;
  logic          error_out;
  logic          busy_out;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .base     (base),
    .exponent (exponent),
    .modulo   (modulo),
    .valid_in (valid_in),
    .c_out    (c_out),
    .valid_out(valid_out),
    .error_out(error_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int c;
    int err;
    int lat;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  int   n_expected = 0;
  int   busy_gap = 0;
  int   err_wo_valid = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: naive repeated multiplication.
  function automatic int model(input int b, input int e, input int m);
    longint r;
    if (m == 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r);
  endfunction

  function automatic int lat_of(input int e, input int m);
    int k;
    if (m == 0) return 1;
    k = 0;
    for (int i = 0; i < int'(EW); i++) if (((e >> i) & 1) != 0) k = i + 1;
`ifdef MOD_EXP_EARLY_EXIT_EN
    return 1 + int'(W) * (1 + k);
`else
    return 1 + int'(W) * (int'(EW) + 1) + 0 * k;
`endif
  endfunction

  // Output monitor: pops the scoreboard on every result strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (error_out && !valid_out) err_wo_valid++;
      if (valid_out) begin
        n_valid++;
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("c_out", c_out, e.c);
          check("error_out", error_out, e.err);
          check("latency", cyc - e.acc_cyc, e.lat);
          check("busy_in_valid_cycle", busy_out, 0);
          check("busy_gap", busy_gap, 0);
          busy_gap = 0;
        end
      end else if (sb.size() > 0 && !busy_out) busy_gap++;
    end
  end

  task automatic do_job(input int b, input int e, input int m, input bit b2b);
    exp_t x;
    int n;
    n = 0;
    @(negedge clk_in);
    while (busy_out && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2000) begin
      check("busy_timeout", 1, 0);
      return;
    end
    if (b2b) check("b2b_in_valid_cycle", valid_out, 1);
    base     = W'(b);
    exponent = EW'(e);
    modulo   = W'(m);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    x.c = model(b, e, m);
    x.err = (m == 0) ? 1 : 0;
    x.lat = lat_of(e, m);
    x.acc_cyc = cyc;
    sb.push_back(x);
    n_expected++;
    @(negedge clk_in);
    valid_in = 1'b0;
    base     = W'($urandom);
    exponent = EW'($urandom);
    modulo   = W'($urandom);
  endtask

  // Requests with a zero modulus while busy; any acceptance shows as an extra result.
  task automatic pulse_while_busy(input int n);
    repeat (n) begin
      @(negedge clk_in);
      if (busy_out) begin
        valid_in = 1'b1;
        base     = W'($urandom);
        modulo   = '0;
      end
      @(negedge clk_in);
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int vb, nv;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_c_out", c_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_error_out", error_out, 0);
    check("rst_busy_out", busy_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    do_job(69, 8, 54, 0);
    check("busy_after_accept", busy_out, 1);
    drain();

    do_job(4, 13, 497, 0);
    pulse_while_busy(6);
    do_job(1023, 1023, 1023, 1);
    pulse_while_busy(4);
    drain();

    do_job(5, 3, 0, 0);
    drain();
    do_job(77, 5, 1, 0);
    do_job(69, 0, 54, 0);
    do_job(0, 0, 97, 0);
    do_job(0, 9, 97, 0);
    for (int i = 0; i < 4; i++) begin
      do_job(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(2, 1023)), 0);
    end
    drain();

    // Reset in the middle of STEP drops the job.
    do_job(4, 13, 497, 0);
    drain();
    do_job(69, 8, 54, 0);
    repeat (30) @(negedge clk_in);
    n_expected = n_expected - sb.size();
    sb.delete();
    busy_gap = 0;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("midrst_c_out", c_out, 0);
    check("midrst_valid_out", valid_out, 0);
    check("midrst_error_out", error_out, 0);
    check("midrst_busy_out", busy_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    nv = n_valid;
    repeat (130) @(negedge clk_in);
    check("dropped_job_no_valid", n_valid, nv);
    vb = 0;
    do_job(69, 8, 54, 0);
    drain();

    repeat (5) @(negedge clk_in);
    check("valid_pulse_count", n_valid, n_expected);
    check("error_without_valid", err_wo_valid, vb);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_exp_engine.md
# mod_exp_engine

Parametrised modular-exponentiation engine computing c = base^exponent mod modulo for independent operand and exponent widths. It is the iterative successor of the fixed-width exponentiator in the RSA datapath. Additions over that block: a busy/accept handshake, an error flag for a zero modulus, and an optional early-exit mode that shortens latency for short exponents. It sits between the key/message register file and the output formatter.

## Interface
- WIDTH, 10: bit width of base, modulo and c_out.
- EXP_WIDTH, WIDTH: bit width of exponent.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-low reset.
- base  input  WIDTH  operand; may be ≥ modulo.
- exponent  input  EXP_WIDTH  exponent.
- modulo  input  WIDTH  modulus.
- valid_in  input  1  request; accepted on a rising edge where valid_in=1 and busy_out=0.
- c_out  output  WIDTH  result; held until the next result is produced.
- valid_out  output  1  one-cycle pulse; c_out/error_out are valid.
- error_out  output  1  asserted with valid_out when modulo==0.
- busy_out  output  1  engine occupied; valid_in is ignored while high.

## Operation
- Reset (rst_in=0 at an edge): state IDLE; c_out=0, valid_out=0, error_out=0, busy_out=0; all internal registers cleared. This applies from any state. An in-flight job is dropped and produces no valid_out.
- Accept: inputs are latched at the accept edge; later input changes have no effect.
- States:
  - IDLE: wait for accept. If modulo==0, go to DONE with error. Otherwise go to REDUCE.
  - REDUCE: r = base mod modulo, computed as base·1 mod modulo with the shared modular multiplier. Then result=1 mod modulo and go to STEP.
  - STEP: one iteration per exponent bit, LSB first. Two modular products run concurrently: result·r if the bit is 1, and r·r. After the last bit, go to DONE.
  - DONE: drive valid_out=1 for one cycle, load c_out, then return to IDLE.
- Modular multiplier: interleaved shift-add, MSB-first over WIDTH multiplier bits, one bit per cycle.
  - Per cycle: acc = 2·acc; if acc ≥ m then acc −= m; if bit then acc += x; if acc ≥ m then acc −= m.
  - acc is WIDTH+1 bits wide. Every stored value stays < modulo.
- Boundary results:
  - modulo==1 → c_out=0, error_out=0.
  - exponent==0 (modulo>1) → c_out=1.
  - base ≡ 0 → c_out=0, except exponent==0, which gives c_out=1.
  - modulo==0 → c_out=0, error_out=1.
- error_out is 0 whenever valid_out is 0.

## Timing
- Accept edge is T0.
- Normal latency (macro absent): valid_out is high in the cycle following edge T0 + 1 + WIDTH·(EXP_WIDTH+1).
  - Breakdown: WIDTH cycles for REDUCE, WIDTH cycles per STEP bit, 1 cycle for DONE.
- Error latency: valid_out and error_out are high in the cycle following edge T0+1.
- busy_out is high from edge T0 through the cycle before valid_out.
  - busy_out is 0 during the valid_out cycle, so valid_in may be accepted in that same cycle (back-to-back jobs).
- c_out updates on the same edge valid_out rises and is otherwise stable.

## Configuration
- MOD_EXP_EARLY_EXIT_EN defined:
  - After each STEP, if the remaining unshifted exponent bits are all zero, go directly to DONE.
  - Latency is 1 + WIDTH·(1+k), where k = index of the highest set exponent bit + 1 (k=0 for exponent==0).
  - Results are identical to the macro-absent build.
- MOD_EXP_EARLY_EXIT_EN undefined: always EXP_WIDTH steps; fixed latency as in Timing.

## Test plan
- WIDTH=EXP_WIDTH=10; base=69, exponent=8, modulo=54:
  - c_out=27, error_out=0.
  - valid_out after 111 cycles, or 51 with MOD_EXP_EARLY_EXIT_EN.
  - busy_out=1 throughout, then 0 in the valid_out cycle.
- base=4, exponent=13, modulo=497 → c_out=445.
- Back-to-back: a second job is accepted in that job's valid_out cycle.
  - Second job: base=1023, exponent=1023, modulo=1023 → c_out=0.
  - valid_in pulses during busy_out=1 are ignored; exactly two valid_out pulses occur.
- Corner cases:
  - modulo=0 → valid_out+error_out after 1 cycle, c_out=0.
  - modulo=1 → c_out=0.
  - exponent=0, modulo=54 → c_out=1.
- Reset mid-op: rst_in=0 for one edge during STEP of job base=69, exponent=8, modulo=54.
  - Next cycle: all outputs 0, busy_out=0.
  - No valid_out for the dropped job.
  - Next job is accepted and computes correctly.
